// File: rtl/twos_compl_serial_pkg.sv
// rtl/twos_compl_serial_pkg.sv - mode/state encodings and helpers for the serial two's-complement unit
package twos_pkg;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_NEG  = 2'b01;
    localparam logic [1:0] MODE_ABS  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Most-negative value: sign bit set, every other bit clear.
    function automatic logic is_most_neg(input logic msb, input logic rest_any);
        return msb & ~rest_any;
    endfunction

    // Reserved mode 2'b11 falls through to pass.
    function automatic logic invert_for(input logic [1:0] mode, input logic msb);
        return (mode == MODE_NEG) | ((mode == MODE_ABS) & msb);
    endfunction

endpackage

// File: rtl/twos_compl_serial_if.sv
// rtl/twos_compl_serial_if.sv - start/busy/done request interface of the serial two's-complement unit
interface twos_compl_serial_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             ovf;

    modport master (
        output start, mode, a,
        input  busy, done, result, ovf
    );

    modport slave (
        input  start, mode, a,
        output busy, done, result, ovf
    );
endinterface

// File: rtl/twos_compl_serial_slice.sv
// rtl/twos_compl_serial_slice.sv - one chunk of conditional invert plus carry-in add
module twos_chunk_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic             inv,
    input  logic             carry_in,
    output logic [CHUNK-1:0] sum,
    output logic             carry_out
);
    assign {carry_out, sum} = {1'b0, a ^ {CHUNK{inv}}} + {{CHUNK{1'b0}}, carry_in};
endmodule

// File: rtl/twos_compl_serial.sv
// rtl/twos_compl_serial.sv - chunk-serial negate/abs/pass unit; TWOS_COMPL_SAT_EN saturates the overflow case
module twos_compl_serial
    import twos_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    twos_compl_serial_if.slave  bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             inv;
    logic             ovf_pend;
    logic             ovf_q;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result_q;

    logic             accept;
    logic             last;
    logic             busy_c;
    logic             done_c;
    logic             inv_sel;
    logic             ovf_sel;
    int               base;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_carry;

    assign inv_sel = invert_for(bus.mode, bus.a[WIDTH-1]);
    assign ovf_sel = inv_sel & is_most_neg(bus.a[WIDTH-1], |bus.a[WIDTH-2:0]);
    assign last    = (cnt == CW'(N - 1));

    always_comb begin
        base    = int'(cnt) * CHUNK;
        chunk_a = op_a[base +: CHUNK];
    end

    twos_chunk_slice #(.CHUNK(CHUNK)) u_slice (
        .a         (chunk_a),
        .inv       (inv),
        .carry_in  (carry),
        .sum       (chunk_sum),
        .carry_out (chunk_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.start) state_next = ST_RUN;
            ST_RUN:  if (last)      state_next = ST_DONE;
            ST_DONE: state_next = bus.start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state == ST_RUN);
        done_c = (state == ST_DONE);
        accept = bus.start & (state != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            carry    <= 1'b0;
            inv      <= 1'b0;
            ovf_pend <= 1'b0;
            ovf_q    <= 1'b0;
            op_a     <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_a     <= bus.a;
            inv      <= inv_sel;
            carry    <= inv_sel;
            cnt      <= '0;
            ovf_pend <= ovf_sel;
            ovf_q    <= 1'b0;
        end else if (busy_c) begin
            result_q[base +: CHUNK] <= chunk_sum;
            carry                   <= chunk_carry;
            cnt                     <= last ? '0 : cnt + CW'(1);
            if (last) begin
                ovf_q <= ovf_pend;
`ifdef TWOS_COMPL_SAT_EN
                // The whole word is overwritten, not just the top chunk.
                if (ovf_pend) begin
                    result_q <= {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end
        end
    end

    assign bus.busy   = busy_c;
    assign bus.done   = done_c;
    assign bus.result = result_q;
    assign bus.ovf    = ovf_q;

endmodule
